braille_pager: RTL and testbench
================================

Name: braille_pager

Overview:
Parametrised multi-cell braille page buffer, successor to the fixed 4-reader block. It loads a braille cell stream from the converter into an internal buffer and presents it NUM_READERS cells at a time on the reader outputs. Pages advance with a user "next" button and, new in this generation, step back with a "prev" button. Partial last pages are padded, and malformed load requests are flagged.

Parameters:
NUM_READERS, 4, number of reader cells shown per page (>=1)
CELL_W, 8, bits per braille cell
DEPTH, 256, buffer capacity in cells
START_CODE, 8'h17, pattern on every cell before the first page
END_CODE, 8'h01, pattern on every cell after the last page
PAD_CODE, 8'h00, pattern for cells past end of text
AUTO_TICKS, 1000, auto-advance period in clk cycles; used only with the optional feature
Derived: SIZE_W = $clog2(DEPTH+1), PAGE_W = $clog2(DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
braille_out  in  CELL_W  cell from converter
braille_size  in  SIZE_W  number of cells in message, sampled on braille_start
braille_start  in  1  one-cycle request to begin a load
braille_valid  in  1  braille_out valid this cycle (LOADING only)
next  in  1  advance button, asynchronous level
prev  in  1  back button, asynchronous level
reader_out  out  NUM_READERS*CELL_W  cell k occupies bits [k*CELL_W +: CELL_W]; cell 0 is leftmost
busy  out  1  high in every state except IDLE
page_idx  out  PAGE_W  current page number while SHOW, else 0
last_page  out  1  high while SHOW is displaying the final page
load_err  out  1  one-cycle pulse when a load request is rejected

Behaviour:
- Reset (synchronous, active-high), valid in any state including mid-load or mid-display:
  - state IDLE; reader_out, page_idx, last_page, load_err, busy all 0; sync flops 0.
  - Buffer RAM is not cleared. Stale cells are never visible because reads beyond size return PAD_CODE.
- Button input: next and prev each pass through a 2-flop synchroniser. A fall pulse is prev_stage & ~sync_stage. The pulse asserts on the 2nd clk after the pin goes low, and reader_out updates on the following clk. All outputs are registered.
- next_fall and prev_fall in the same cycle: both ignored.
- Page arithmetic:
  - pages = ceil(size/NUM_READERS); last = pages-1.
  - Cell k of page p = buffer[p*NUM_READERS+k] if that index < size, else PAD_CODE.
- States:
  - IDLE:
    - braille_start with 1 <= braille_size <= DEPTH: latch size, wr_ptr=0, go to LOADING.
    - braille_start with size 0 or size > DEPTH: load_err=1 for one cycle, stay IDLE, reader_out unchanged.
    - reader_out holds its last value (END_CODE after a completed session).
  - LOADING:
    - Each braille_valid cycle writes buffer[wr_ptr] and increments wr_ptr; gaps in braille_valid are allowed.
    - On the cycle the write index equals size-1, go to START.
    - braille_start, next and prev are ignored.
  - START: reader_out = START_CODE on all cells (registered on entry). next_fall goes to SHOW with p=0; prev_fall is ignored.
  - SHOW:
    - next_fall: if p<last then p+1, else go to END.
    - prev_fall: if p>0 then p-1, else go back to START.
    - braille_start is ignored.
  - END: reader_out = END_CODE on all cells for one cycle, then IDLE. reader_out keeps END_CODE.
- Size is exactly a multiple of NUM_READERS: no pad cells. size < NUM_READERS: a single padded page.

Optional Feature:
Macro BRAILLE_PAGER_AUTOADV_EN.
- Defined: in SHOW, a counter increments each clk and clears on any page change or state entry. On reaching AUTO_TICKS-1 it acts as a next_fall, including the END transition on the last page. A manual next or prev in that cycle takes priority and clears the counter.
- Undefined: no counter logic; pages change only on the buttons.

Test Plan:
1. NUM_READERS=4, braille_start size=10, data 0x01..0x0A, then next x5 -> START_CODE x4; pages [01 02 03 04], [05 06 07 08], [09 0A 00 00] with last_page=1; then END_CODE x4; busy drops; IDLE.
2. Size 10 at page 2, prev -> page 1 [05..08], page_idx=1. prev, then prev again -> page 0, then START_CODE x4.
3. braille_start with size 0, and again with size 257 (DEPTH=256) -> load_err one-cycle pulse each time; busy stays 0; reader_out unchanged.
4. Size 8, braille_valid toggled 1/0 during load -> exactly 8 cells stored; 2 pages with no padding; next on page 1 -> END.
5. reset asserted mid-LOADING (after 3 of 10 cells), then a fresh load of size 4 [AA BB CC DD] -> outputs 0 after reset; new page shows AA BB CC DD.
6. next and prev fall in the same cycle during SHOW -> page_idx and reader_out unchanged. With BRAILLE_PAGER_AUTOADV_EN defined and AUTO_TICKS=16 -> page advances every 16 clks and reaches END unaided.

Source files
------------

// File: rtl/braille_pager.sv
// ============================================================================
// Module   : braille_pager
// Purpose  : Multi-cell braille page buffer. Loads a cell stream from the
//            braille converter into an internal buffer and presents it
//            NUM_READERS cells at a time. Pages move forward on the "next"
//            button and back on the "prev" button; short last pages are
//            padded and malformed load requests are flagged.
// Optional : BRAILLE_PAGER_AUTOADV_EN - when defined, SHOW advances by itself
//            every AUTO_TICKS clocks as if "next" had been pressed.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            braille_out/_size     - cell data / message length in cells
//            braille_start/_valid  - load request / data strobe
//            next, prev            - asynchronous active-low button levels
//            reader_out            - NUM_READERS cells, cell 0 in the LSBs
//            busy, page_idx,       - status: not IDLE, current page,
//            last_page, load_err     final page shown, rejected load pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module braille_pager #(
    parameter int                NUM_READERS = 4,
    parameter int                CELL_W      = 8,
    parameter int                DEPTH       = 256,
    parameter logic [CELL_W-1:0] START_CODE  = 8'h17,
    parameter logic [CELL_W-1:0] END_CODE    = 8'h01,
    parameter logic [CELL_W-1:0] PAD_CODE    = 8'h00,
    parameter int                AUTO_TICKS  = 1000,
    localparam int               SIZE_W      = $clog2(DEPTH + 1),
    localparam int               PAGE_W      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CELL_W-1:0]             braille_out,
    input  logic [SIZE_W-1:0]             braille_size,
    input  logic                          braille_start,
    input  logic                          braille_valid,
    input  logic                          next,
    input  logic                          prev,
    output logic [NUM_READERS*CELL_W-1:0] reader_out,
    output logic                          busy,
    output logic [PAGE_W-1:0]             page_idx,
    output logic                          last_page,
    output logic                          load_err
);

    localparam int RD_W = NUM_READERS * CELL_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADING = 3'd1,
        S_START   = 3'd2,
        S_SHOW    = 3'd3,
        S_END     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [SIZE_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PAGE_W-1:0]  page_q, page_d;
    logic [RD_W-1:0]    reader_q, reader_d;
    logic               last_page_q, last_page_d;
    logic               load_err_q, load_err_d;
    logic               busy_q, busy_d;

    logic [CELL_W-1:0]  mem_q [DEPTH];

    // Button synchronisers: meta -> sync -> delayed copy for edge detect.
    logic               next_meta_q, next_sync_q, next_dly_q;
    logic               prev_meta_q, prev_sync_q, prev_dly_q;
    logic               w_next_fall, w_prev_fall;
    logic               w_next_only, w_prev_only;
    logic               w_auto, w_adv;

    logic               w_fill_start, w_fill_end, w_load_page;
    logic [PAGE_W-1:0]  w_last;
    logic [RD_W-1:0]    w_cells;

    assign w_next_fall = next_dly_q & ~next_sync_q;
    assign w_prev_fall = prev_dly_q & ~prev_sync_q;
    // Simultaneous presses cancel each other out.
    assign w_next_only = w_next_fall & ~w_prev_fall;
    assign w_prev_only = w_prev_fall & ~w_next_fall;

    // Index of the final page: ceil(size / NUM_READERS) - 1.
    assign w_last = PAGE_W'((32'(size_q) + 32'(NUM_READERS) - 32'd1) / 32'(NUM_READERS) - 32'd1);

`ifdef BRAILLE_PAGER_AUTOADV_EN
    localparam int CNT_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Manual presses (even cancelled pairs) take priority over the timer.
    assign w_auto = (state_q == S_SHOW) && (cnt_q == CNT_W'(AUTO_TICKS - 1))
                    && !w_next_fall && !w_prev_fall;

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_SHOW) && (state_d == S_SHOW) && (page_d == page_q)
            && !w_next_fall && !w_prev_fall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    assign w_adv = w_next_only | w_auto;

    // Cells of the page about to be displayed; reads past size are padding,
    // which also hides stale buffer contents from earlier messages.
    for (genvar k = 0; k < NUM_READERS; k++) begin : g_cell
        logic [31:0] w_idx;
        assign w_idx = 32'(page_d) * 32'(NUM_READERS) + 32'(k);
        assign w_cells[k*CELL_W +: CELL_W] =
            (w_idx < 32'(size_q)) ? mem_q[w_idx[PAGE_W-1:0]] : PAD_CODE;
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        wr_ptr_d     = wr_ptr_q;
        page_d       = page_q;
        load_err_d   = 1'b0;
        w_fill_start = 1'b0;
        w_fill_end   = 1'b0;
        w_load_page  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (braille_start) begin
                    if ((braille_size != '0) && (braille_size <= SIZE_W'(DEPTH))) begin
                        size_d   = braille_size;
                        wr_ptr_d = '0;
                        state_d  = S_LOADING;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            S_LOADING: begin
                if (braille_valid) begin
                    wr_ptr_d = wr_ptr_q + SIZE_W'(1);
                    if (wr_ptr_q == size_q - SIZE_W'(1)) begin
                        state_d      = S_START;
                        page_d       = '0;
                        w_fill_start = 1'b1;
                    end
                end
            end
            S_START: begin
                if (w_next_only) begin
                    state_d     = S_SHOW;
                    page_d      = '0;
                    w_load_page = 1'b1;
                end
            end
            S_SHOW: begin
                if (w_adv) begin
                    if (page_q < w_last) begin
                        page_d      = page_q + PAGE_W'(1);
                        w_load_page = 1'b1;
                    end else begin
                        state_d    = S_END;
                        page_d     = '0;
                        w_fill_end = 1'b1;
                    end
                end else if (w_prev_only) begin
                    if (page_q != '0) begin
                        page_d      = page_q - PAGE_W'(1);
                        w_load_page = 1'b1;
                    end else begin
                        state_d      = S_START;
                        page_d       = '0;
                        w_fill_start = 1'b1;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                page_d  = '0;
            end
        endcase
    end

    // Registered output values.
    always_comb begin
        reader_d = reader_q;
        if (w_fill_start) begin
            reader_d = {NUM_READERS{START_CODE}};
        end else if (w_fill_end) begin
            reader_d = {NUM_READERS{END_CODE}};
        end else if (w_load_page) begin
            reader_d = w_cells;
        end
        last_page_d = (state_d == S_SHOW) && (page_d == w_last);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            size_q      <= '0;
            wr_ptr_q    <= '0;
            page_q      <= '0;
            reader_q    <= '0;
            last_page_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            next_meta_q <= 1'b0;
            next_sync_q <= 1'b0;
            next_dly_q  <= 1'b0;
            prev_meta_q <= 1'b0;
            prev_sync_q <= 1'b0;
            prev_dly_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            wr_ptr_q    <= wr_ptr_d;
            page_q      <= page_d;
            reader_q    <= reader_d;
            last_page_q <= last_page_d;
            load_err_q  <= load_err_d;
            busy_q      <= busy_d;
            next_meta_q <= next;
            next_sync_q <= next_meta_q;
            next_dly_q  <= next_sync_q;
            prev_meta_q <= prev;
            prev_sync_q <= prev_meta_q;
            prev_dly_q  <= prev_sync_q;
        end
    end

    // Buffer RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOADING) && braille_valid) begin
            mem_q[wr_ptr_q[PAGE_W-1:0]] <= braille_out;
        end
    end

    assign reader_out = reader_q;
    assign busy       = busy_q;
    assign page_idx   = page_q;
    assign last_page  = last_page_q;
    assign load_err   = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_braille_pager.sv
// ============================================================================
// Module   : tb_braille_pager
// Purpose  : Self-checking bench for braille_pager (default build). Drives
//            directed scenarios and randomised loads / button walks, and
//            compares against a page-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_braille_pager;

    localparam int NR = 4;
    localparam int CW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [CW-1:0]      braille_out;
    logic [8:0]         braille_size;
    logic               braille_start;
    logic               braille_valid;
    logic               next;
    logic               prev;
    logic [NR*CW-1:0]   reader_out;
    logic               busy;
    logic [7:0]         page_idx;
    logic               last_page;
    logic               load_err;

    braille_pager dut (
        .clk           (clk),
        .reset         (reset),
        .braille_out   (braille_out),
        .braille_size  (braille_size),
        .braille_start (braille_start),
        .braille_valid (braille_valid),
        .next          (next),
        .prev          (prev),
        .reader_out    (reader_out),
        .busy          (busy),
        .page_idx      (page_idx),
        .last_page     (last_page),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = idle (showing held value), 1 = start screen,
    // 2 = showing page mp.
    int          mode;
    int          mp;
    int          msize;
    logic [31:0] held;
    logic [7:0]  mdata [$];

    function automatic logic [31:0] fill(input logic [7:0] c);
        return {NR{c}};
    endfunction

    function automatic int last_pg();
        return (msize + NR - 1) / NR - 1;
    endfunction

    function automatic logic [31:0] page_vec(input int p);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = p * NR + k;
            v[k*CW +: CW] = (idx < msize) ? mdata[idx] : 8'h00;
        end
        return v;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] er;
        int          ep;
        logic        el;
        logic        eb;
        case (mode)
            1:       begin er = fill(8'h17);  ep = 0;  el = 1'b0;            eb = 1'b1; end
            2:       begin er = page_vec(mp); ep = mp; el = (mp == last_pg()); eb = 1'b1; end
            default: begin er = held;         ep = 0;  el = 1'b0;            eb = 1'b0; end
        endcase
        cmp({tag, "_reader"}, reader_out, er);
        cmp({tag, "_page"},   32'(page_idx), 32'(ep));
        cmp({tag, "_last"},   32'(last_page), 32'(el));
        cmp({tag, "_busy"},   32'(busy), 32'(eb));
    endtask

    // which: 0 = next, 1 = prev, 2 = both together
    task automatic button(input int which, input string tag);
        @(negedge clk);
        if (which != 1) next = 1'b0;
        if (which != 0) prev = 1'b0;
        repeat (4) @(negedge clk);
        next = 1'b1;
        prev = 1'b1;
        repeat (2) @(negedge clk);
        if (which == 0) begin
            if (mode == 1) begin
                mode = 2; mp = 0;
            end else if (mode == 2) begin
                if (mp < last_pg()) mp++;
                else begin mode = 0; held = fill(8'h01); end
            end
        end else if (which == 1) begin
            if (mode == 2) begin
                if (mp > 0) mp--;
                else mode = 1;
            end
        end
        check_all(tag);
    endtask

    // gapmode: 0 none, 1 alternate valid 1/0, 2 random gaps.
    // mdata must already hold sz cells.
    task automatic do_load(input int sz, input int gapmode, input string tag);
        @(negedge clk);
        braille_start = 1'b1;
        braille_size  = 9'(sz);
        @(negedge clk);
        braille_start = 1'b0;
        for (int i = 0; i < sz; i++) begin
            int gaps;
            gaps = (gapmode == 1) ? ((i > 0) ? 1 : 0) :
                   (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                braille_valid = 1'b0;
                braille_out   = 8'($urandom);
                @(negedge clk);
            end
            braille_valid = 1'b1;
            braille_out   = mdata[i];
            @(negedge clk);
        end
        braille_valid = 1'b0;
        braille_out   = 8'($urandom);
        @(negedge clk);
        msize = sz;
        mode  = 1;
        mp    = 0;
        check_all(tag);
    endtask

    task automatic bad_load(input int sz, input string tag);
        @(negedge clk);
        braille_start = 1'b1;
        braille_size  = 9'(sz);
        @(negedge clk);
        braille_start = 1'b0;
        cmp({tag, "_pulse"}, 32'(load_err), 32'd1);
        @(negedge clk);
        cmp({tag, "_clear"}, 32'(load_err), 32'd0);
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; braille_out = '0; braille_size = '0;
        braille_start = 1'b0; braille_valid = 1'b0;
        next = 1'b1; prev = 1'b1;
        mode = 0; mp = 0; msize = 0; held = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset");
        cmp("reset_err", 32'(load_err), 32'd0);

        // Scenario 1: size 10, walk forward to END.
        mdata.delete();
        for (int i = 1; i <= 10; i++) mdata.push_back(8'(i));
        do_load(10, 0, "t1_start");
        cmp("t1_startcode", reader_out, 32'h17171717);
        button(0, "t1_p0");
        cmp("t1_p0_lit", reader_out, 32'h04030201);
        button(0, "t1_p1");
        button(0, "t1_p2");
        cmp("t1_p2_lit", reader_out, 32'h00000A09);
        button(0, "t1_end");
        cmp("t1_endcode", reader_out, 32'h01010101);
        button(0, "t1_idle_next");

        // Scenario 2: walk back from page 2 to START; prev ignored there.
        do_load(10, 0, "t2_start");
        button(0, "t2_p0");
        button(0, "t2_p1");
        button(0, "t2_p2");
        button(1, "t2_back1");
        cmp("t2_back1_lit", reader_out, 32'h08070605);
        button(1, "t2_back0");
        button(1, "t2_start_again");
        button(1, "t2_start_prev");

        // Scenario 3: rejected loads (in START state they are ignored, so go idle).
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        mode = 0; held = '0;
        bad_load(0, "t3_size0");
        bad_load(257, "t3_size257");

        // Scenario 4: size 8 with valid toggling.
        mdata.delete();
        for (int i = 0; i < 8; i++) mdata.push_back(8'($urandom));
        do_load(8, 1, "t4_start");
        button(0, "t4_p0");
        button(0, "t4_p1");
        button(0, "t4_end");

        // Scenario 5: reset mid-load, then fresh load.
        @(negedge clk);
        braille_start = 1'b1; braille_size = 9'd10;
        @(negedge clk);
        braille_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            braille_valid = 1'b1; braille_out = 8'(8'h50 + i);
            @(negedge clk);
        end
        braille_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mode = 0; held = '0;
        check_all("t5_reset");
        cmp("t5_reset_err", 32'(load_err), 32'd0);
        mdata.delete();
        mdata.push_back(8'hAA); mdata.push_back(8'hBB);
        mdata.push_back(8'hCC); mdata.push_back(8'hDD);
        do_load(4, 0, "t5_start");
        button(0, "t5_p0");
        cmp("t5_p0_lit", reader_out, 32'hDDCCBBAA);

        // Scenario 6: simultaneous next+prev ignored.
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        mode = 0; held = '0;
        mdata.delete();
        for (int i = 1; i <= 10; i++) mdata.push_back(8'(i));
        do_load(10, 0, "t6_start");
        button(0, "t6_p0");
        button(0, "t6_p1");
        button(2, "t6_both");
        button(2, "t6_both2");

        // Randomised loads and button walks.
        for (int r = 0; r < 5; r++) begin
            int sz;
            reset = 1'b1; @(negedge clk); reset = 1'b0;
            mode = 0; held = '0;
            sz = int'($urandom_range(1, 24));
            mdata.delete();
            for (int i = 0; i < sz; i++) mdata.push_back(8'($urandom));
            do_load(sz, 2, "rnd_start");
            for (int s = 0; s < 12; s++) begin
                int w;
                w = int'($urandom_range(0, 9));
                button((w < 6) ? 0 : (w < 9) ? 1 : 2, "rnd_step");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
